// File: rtl/load_unit.sv
// load_unit: sequential load unit for the data-memory path.
//
// Accepts a load request (byte address + funct3), issues one or two
// word-aligned reads to data memory, extracts the addressed byte lanes,
// applies sign/zero extension and returns the result on a valid/ready port.
//
// Parameters
//   ARCH        data/address width, 32 or 64
//   MISALIGN_EN 1: loads crossing a word boundary are split into two reads
//               0: such loads return an error response
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid_in    request valid
//   req_ready_out   unit idle and able to accept a request
//   req_addr_in     byte address of the load
//   req_func3_in    load type (funct3)
//   dmem_re_out     data-memory read enable
//   dmem_addr_out   word-aligned read address
//   dmem_rdata_in   read data, valid the cycle after dmem_re_out
//   rsp_valid_out   response valid
//   rsp_ready_in    consumer accepts the response
//   rsp_data_out    extended load result
//   rsp_err_out     misaligned (when not splitting) or illegal funct3
module load_unit #(
  parameter int ARCH        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [ARCH-1:0] req_addr_in,
  input  logic [2:0]      req_func3_in,
  output logic            dmem_re_out,
  output logic [ARCH-1:0] dmem_addr_out,
  input  logic [ARCH-1:0] dmem_rdata_in,
  output logic            rsp_valid_out,
  input  logic            rsp_ready_in,
  output logic [ARCH-1:0] rsp_data_out,
  output logic            rsp_err_out
);

  localparam int BYTES = ARCH / 8;
  localparam int OFFW  = $clog2(BYTES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    LAT  = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } state_t;

  // funct3 values legal for this width; LD and LWU exist only on 64-bit
  function automatic logic func3_legal(input logic [2:0] f);
    logic ok;
    case (f)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ok = 1'b1;
      3'd3, 3'd6:                   ok = (ARCH == 64);
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // access size in bytes
  function automatic logic [3:0] func3_size(input logic [2:0] f);
    logic [3:0] sz;
    case (f)
      3'd0, 3'd4: sz = 4'd1;
      3'd1, 3'd5: sz = 4'd2;
      3'd2, 3'd6: sz = 4'd4;
      3'd3:       sz = 4'd8;
      default:    sz = 4'd1;
    endcase
    return sz;
  endfunction

  // LB/LH/LW/LD sign-extend; the unsigned forms have funct3[2] set
  function automatic logic func3_signed(input logic [2:0] f);
    return ~f[2];
  endfunction

  // access runs past the end of the addressed word
  function automatic logic is_split(input logic [OFFW-1:0] off, input logic [2:0] f);
    return (int'(off) + int'(func3_size(f))) > BYTES;
  endfunction

  // shift the addressed bytes down to lane 0, then sign/zero extend.
  // A full-width load has nbits == ARCH, so it passes through untouched.
  function automatic logic [ARCH-1:0] extract(input logic [2*ARCH-1:0] cat,
                                              input logic [OFFW-1:0]   off,
                                              input logic [2:0]        f);
    logic [2*ARCH-1:0] sh;
    logic [ARCH-1:0]   res;
    logic              sbit;
    int                nbits;
    sh    = cat >> {off, 3'b000};
    nbits = 8 * int'(func3_size(f));
    sbit  = 1'b0;
    res   = {ARCH{1'b0}};
    for (int i = 0; i < ARCH; i++) begin
      sbit   = sbit | (sh[i] & (i == nbits - 1));
      res[i] = (i < nbits) ? sh[i] : (sbit & func3_signed(f));
    end
    return res;
  endfunction

  state_t            state_r, state_s;
  logic [ARCH-1:0]   addr_r;
  logic [2:0]        func3_r;
  logic [ARCH-1:0]   word0_r;
  logic              req_ready_r, dmem_re_r, rsp_valid_r, rsp_err_r;
  logic [ARCH-1:0]   dmem_addr_r, rsp_data_r;
  logic              req_ready_s, dmem_re_s, rsp_valid_s, rsp_err_s;
  logic [ARCH-1:0]   dmem_addr_s, rsp_data_s;
  logic              accept_s, req_split_s, cur_split_s;
  logic [ARCH-1:0]   req_base_s, cur_base_s;
  logic [2*ARCH-1:0] cat_s;

  // request decode and address helpers
  always_comb begin
    accept_s    = req_valid_in & req_ready_r & (state_r == IDLE);
    req_split_s = is_split(req_addr_in[OFFW-1:0], req_func3_in);
    cur_split_s = is_split(addr_r[OFFW-1:0], func3_r);
    req_base_s  = {req_addr_in[ARCH-1:OFFW], {OFFW{1'b0}}};
    cur_base_s  = {addr_r[ARCH-1:OFFW], {OFFW{1'b0}}};
    // the second word arrives in LAT; word1 is zero for a single read
    if (cur_split_s) begin
      cat_s = {dmem_rdata_in, word0_r};
    end else begin
      cat_s = {{ARCH{1'b0}}, dmem_rdata_in};
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (!func3_legal(req_func3_in) || (req_split_s && !MISALIGN_EN)) begin
            state_s = ERR;
          end else begin
            state_s = RD0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD0:  state_s = cur_split_s ? RD1 : LAT;
      RD1:  state_s = LAT;
      LAT:  state_s = RESP;
      RESP: state_s = rsp_ready_in ? IDLE : RESP;
      ERR:  state_s = rsp_ready_in ? IDLE : ERR;
      default: state_s = IDLE;
    endcase
  end

  // next values of the registered outputs, decoded from the next state
  always_comb begin
    req_ready_s = (state_s == IDLE);
    rsp_valid_s = (state_s == RESP) || (state_s == ERR);
    rsp_err_s   = (state_s == ERR);
    dmem_re_s   = 1'b0;
    dmem_addr_s = {ARCH{1'b0}};
    case (state_s)
      // RD0 is only entered from IDLE, before addr_r has been loaded
      RD0: begin
        dmem_re_s   = 1'b1;
        dmem_addr_s = req_base_s;
      end
      RD1: begin
        dmem_re_s   = 1'b1;
        dmem_addr_s = cur_base_s + ARCH'(BYTES);
      end
      default: begin
        dmem_re_s   = 1'b0;
        dmem_addr_s = {ARCH{1'b0}};
      end
    endcase
    case (state_r)
      LAT:     rsp_data_s = extract(cat_s, addr_r[OFFW-1:0], func3_r);
      RESP:    rsp_data_s = rsp_ready_in ? {ARCH{1'b0}} : rsp_data_r;
      default: rsp_data_s = {ARCH{1'b0}};
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      dmem_re_r   <= 1'b0;
      dmem_addr_r <= {ARCH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {ARCH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= req_ready_s;
      dmem_re_r   <= dmem_re_s;
      dmem_addr_r <= dmem_addr_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  // request capture and first-word capture for split loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= {ARCH{1'b0}};
      func3_r <= 3'd0;
      word0_r <= {ARCH{1'b0}};
    end else begin
      if (accept_s) begin
        addr_r  <= req_addr_in;
        func3_r <= req_func3_in;
      end
      if (state_r == RD1) begin
        word0_r <= dmem_rdata_in;
      end
    end
  end

  assign req_ready_out = req_ready_r;
  assign dmem_re_out   = dmem_re_r;
  assign dmem_addr_out = dmem_addr_r;
  assign rsp_valid_out = rsp_valid_r;
  assign rsp_data_out  = rsp_data_r;
  assign rsp_err_out   = rsp_err_r;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: three instances (32-bit splitting, 32-bit
// non-splitting, 64-bit splitting) share one clock and reset. Memory is a
// byte-addressed model (hash plus preset bytes); expected results are built
// byte by byte from that model.
module tb_load_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid [3];
  logic [63:0] req_addr  [3];
  logic [2:0]  req_f3    [3];
  logic        rsp_ready [3];
  logic [63:0] rdata     [3];

  logic        rdy_0, re_0, val_0, err_0;
  logic [31:0] addr_0, data_0;
  logic        rdy_1, re_1, val_1, err_1;
  logic [31:0] addr_1, data_1;
  logic        rdy_2, re_2, val_2, err_2;
  logic [63:0] addr_2, data_2;

  logic        o_rdy [3];
  logic        o_re  [3];
  logic        o_val [3];
  logic        o_err [3];
  logic [63:0] o_addr[3];
  logic [63:0] o_data[3];

  always_comb begin
    o_rdy[0] = rdy_0; o_re[0] = re_0; o_val[0] = val_0; o_err[0] = err_0;
    o_addr[0] = {32'h0, addr_0}; o_data[0] = {32'h0, data_0};
    o_rdy[1] = rdy_1; o_re[1] = re_1; o_val[1] = val_1; o_err[1] = err_1;
    o_addr[1] = {32'h0, addr_1}; o_data[1] = {32'h0, data_1};
    o_rdy[2] = rdy_2; o_re[2] = re_2; o_val[2] = val_2; o_err[2] = err_2;
    o_addr[2] = addr_2; o_data[2] = data_2;
  end

  load_unit #(.ARCH(32), .MISALIGN_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid[0]), .req_ready_out(rdy_0),
    .req_addr_in(req_addr[0][31:0]), .req_func3_in(req_f3[0]),
    .dmem_re_out(re_0), .dmem_addr_out(addr_0), .dmem_rdata_in(rdata[0][31:0]),
    .rsp_valid_out(val_0), .rsp_ready_in(rsp_ready[0]),
    .rsp_data_out(data_0), .rsp_err_out(err_0));

  load_unit #(.ARCH(32), .MISALIGN_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid[1]), .req_ready_out(rdy_1),
    .req_addr_in(req_addr[1][31:0]), .req_func3_in(req_f3[1]),
    .dmem_re_out(re_1), .dmem_addr_out(addr_1), .dmem_rdata_in(rdata[1][31:0]),
    .rsp_valid_out(val_1), .rsp_ready_in(rsp_ready[1]),
    .rsp_data_out(data_1), .rsp_err_out(err_1));

  load_unit #(.ARCH(64), .MISALIGN_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid[2]), .req_ready_out(rdy_2),
    .req_addr_in(req_addr[2]), .req_func3_in(req_f3[2]),
    .dmem_re_out(re_2), .dmem_addr_out(addr_2), .dmem_rdata_in(rdata[2]),
    .rsp_valid_out(val_2), .rsp_ready_in(rsp_ready[2]),
    .rsp_data_out(data_2), .rsp_err_out(err_2));

  // ---------------- memory model ----------------
  typedef struct {
    int          inst;
    logic [63:0] addr;
    logic [7:0]  b;
  } pre_t;
  pre_t pre_q[$];

  function automatic int arch_of(input int inst);
    return (inst == 2) ? 64 : 32;
  endfunction

  function automatic logic [63:0] mask_of(input int inst);
    return (inst == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [7:0] byte_at(input int inst, input logic [63:0] a);
    logic [7:0] v;
    v = (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ a[63:56] ^ 8'(inst * 53);
    foreach (pre_q[i]) begin
      if (pre_q[i].inst == inst && pre_q[i].addr == a) v = pre_q[i].b;
    end
    return v;
  endfunction

  function automatic logic [63:0] word_at(input int inst, input logic [63:0] a);
    logic [63:0] w;
    w = 64'h0;
    for (int k = 0; k < arch_of(inst) / 8; k++)
      w[8*k +: 8] = byte_at(inst, (a + 64'(k)) & mask_of(inst));
    return w;
  endfunction

  task automatic preset_word(input int inst, input logic [63:0] a,
                             input logic [63:0] w, input int nb);
    for (int k = 0; k < nb; k++) pre_q.push_back('{inst, a + 64'(k), w[8*k +: 8]});
  endtask

  // read data one cycle after the enable; garbage when not reading
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_re[i]) rdata[i] <= word_at(i, o_addr[i]);
      else         rdata[i] <= {$urandom, $urandom};
    end
  end

  // ---------------- reference model ----------------
  function automatic void model(input int inst, input logic [63:0] a, input logic [2:0] f,
                                output logic err, output logic [63:0] data,
                                output int nreads);
    int arch, nb, sz, off;
    logic legal, split;
    arch  = arch_of(inst);
    nb    = arch / 8;
    sz    = 1 << int'(f[1:0]);
    off   = int'(a[2:0]) % nb;
    split = (off + sz) > nb;
    legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5) ||
            ((arch == 64) && ((f == 3'd3) || (f == 3'd6)));
    data  = 64'h0;
    if (!legal || (split && inst == 1)) begin
      err    = 1'b1;
      nreads = 0;
    end else begin
      err    = 1'b0;
      nreads = split ? 2 : 1;
      for (int k = 0; k < sz; k++)
        data[8*k +: 8] = byte_at(inst, (a + 64'(k)) & mask_of(inst));
      if (!f[2] && (8 * sz < arch) && data[8*sz-1])
        data = data | (mask_of(inst) & ~((64'd1 << (8 * sz)) - 64'd1));
    end
  endfunction

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [63:0] last_data;
  logic        last_err;

  task automatic run_load(input int inst, input logic [63:0] a, input logic [2:0] f,
                          input int hold);
    logic        exp_err;
    logic [63:0] exp_data, base, msk;
    int          exp_nr, exp_lat, lat;
    logic [63:0] rd_addr[$];
    int          rd_cyc[$];
    msk = mask_of(inst);
    model(inst, a & msk, f, exp_err, exp_data, exp_nr);
    exp_lat = exp_err ? 1 : ((exp_nr == 2) ? 4 : 3);
    base = (a & msk) & ~(64'(arch_of(inst) / 8) - 64'd1);

    @(negedge clk);
    check("req_ready_idle", 64'(o_rdy[inst]), 64'd1);
    req_valid[inst] = 1'b1;
    req_addr[inst]  = a & msk;
    req_f3[inst]    = f;
    rsp_ready[inst] = (hold == 0);
    @(posedge clk);
    #1 req_valid[inst] = 1'b0;

    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      if (o_re[inst]) begin
        rd_addr.push_back(o_addr[inst]);
        rd_cyc.push_back(c);
      end
      if (o_val[inst]) lat = c;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (lat != 0) begin
      last_data = o_data[inst];
      last_err  = o_err[inst];
      check("rsp_err", 64'(o_err[inst]), 64'(exp_err));
      check("rsp_data", o_data[inst], exp_data);
      check("num_reads", 64'(rd_addr.size()), 64'(exp_nr));
      if (rd_addr.size() >= 1) begin
        check("rd0_addr", rd_addr[0], base);
        check("rd0_cycle", 64'(rd_cyc[0]), 64'd1);
      end
      if (rd_addr.size() >= 2) begin
        check("rd1_addr", rd_addr[1], (base + 64'(arch_of(inst) / 8)) & msk);
        check("rd1_cycle", 64'(rd_cyc[1]), 64'd2);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", 64'(o_val[inst]), 64'd1);
        check("hold_data", o_data[inst], exp_data);
        check("hold_err", 64'(o_err[inst]), 64'(exp_err));
        check("hold_ready", 64'(o_rdy[inst]), 64'd0);
      end
      rsp_ready[inst] = 1'b1;
      @(negedge clk);
      check("post_valid", 64'(o_val[inst]), 64'd0);
      check("post_ready", 64'(o_rdy[inst]), 64'd1);
      check("post_re", 64'(o_re[inst]), 64'd0);
    end
    rsp_ready[inst] = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_ready"}, 64'(o_rdy[i]), 64'd1);
      check({tag, "_re"},    64'(o_re[i]),  64'd0);
      check({tag, "_addr"},  o_addr[i],     64'd0);
      check({tag, "_valid"}, 64'(o_val[i]), 64'd0);
      check({tag, "_data"},  o_data[i],     64'd0);
      check({tag, "_err"},   64'(o_err[i]), 64'd0);
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [63:0] a;
    logic [2:0]  f;
    int          inst, hold;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 64'h0;
      req_f3[i]    = 3'd0;
      rsp_ready[i] = 1'b1;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // byte load with sign extension
    preset_word(0, 64'h100, 64'h80FF_1234, 4);
    run_load(0, 64'h103, 3'd0, 0);
    check("tp_lb", last_data, 64'hFFFF_FF80);

    // halfword unsigned / signed
    preset_word(0, 64'h100, 64'hBEEF_0000, 4);
    run_load(0, 64'h102, 3'd5, 0);
    check("tp_lhu", last_data, 64'h0000_BEEF);
    run_load(0, 64'h102, 3'd1, 0);
    check("tp_lh", last_data, 64'hFFFF_BEEF);

    // split word load
    preset_word(0, 64'h200, 64'h44AA_BBCC, 4);
    preset_word(0, 64'h204, 64'h0011_2233, 4);
    run_load(0, 64'h203, 3'd2, 0);
    check("tp_lw_split", last_data, 64'h1122_3344);

    // misaligned without splitting, and illegal funct3 on 32-bit
    run_load(1, 64'h003, 3'd1, 0);
    check("tp_mis_err", 64'(last_err), 64'd1);
    check("tp_mis_data", last_data, 64'd0);
    run_load(1, 64'h000, 3'd3, 0);
    check("tp_ld32_err", 64'(last_err), 64'd1);

    // 64-bit word loads
    preset_word(2, 64'h08, 64'h8765_4321_0000_0000, 8);
    run_load(2, 64'h0C, 3'd6, 0);
    check("tp_lwu64", last_data, 64'h0000_0000_8765_4321);
    run_load(2, 64'h0C, 3'd2, 0);
    check("tp_lw64", last_data, 64'hFFFF_FFFF_8765_4321);

    // backpressure for five cycles
    run_load(0, 64'h103, 3'd0, 5);

    // reset while the second read is in flight
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 64'h203;
    req_f3[0]    = 3'd2;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rd1_re_before_rst", 64'(o_re[0]), 64'd1);
    check("rd1_addr_before_rst", o_addr[0], 64'h204);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_val[0]) seen = 1'b1;
    end
    check("no_rsp_after_rst", 64'(seen), 64'd0);

    // randomized loads across all three configurations
    for (int t = 0; t < 180; t++) begin
      inst = $urandom_range(0, 2);
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a[63:8] = {56{1'b1}};
      f    = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_load(inst, a, f, hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
